// File: rtl/bomb_pkg.sv
// Shared types and widths for the bomb-defusal game controller.
package bomb_pkg;
  localparam int SEC_W    = 8;
  localparam int STRIKE_W = 2;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {IDLE, ARMED, DISARMED, EXPLODED} state_t;
endpackage

// File: rtl/bomb_sec_tick.sv
// Countdown-second divider: one-cycle tick every TICK_DIV enabled cycles.
module sec_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Held at zero whenever disabled so every game starts on a full second.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign tick = en && (count == LAST);
endmodule

// File: rtl/bomb_ctrl.sv
// Game FSM: latches the secret on arm, counts down seconds, scores guesses.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int COUNT_INIT  = 60,
  parameter int MAX_STRIKES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              enter,
  input  logic [CODE_W-1:0] code_sw,
  output logic              armed,
  output logic              explosion,
  output logic              disarm,
  output logic [SEC_W-1:0]  seconds_left,
  output logic [STRIKE_W-1:0] strikes
);
  localparam logic [SEC_W-1:0]    SEC_INIT = SEC_W'(COUNT_INIT);
  localparam logic [STRIKE_W-1:0] STR_MAX  = STRIKE_W'(MAX_STRIKES);

  state_t              state;
  logic [CODE_W-1:0]   secret;
  logic                tick;
  logic                arm;
  logic                hit, miss, strike_out, time_out;
  logic [STRIKE_W-1:0] strikes_nx;

  assign arm        = (state == IDLE) && start;
  assign hit        = enter && (code_sw == secret);
  assign miss       = enter && (code_sw != secret);
  assign strikes_nx = strikes + 1'b1;
  assign strike_out = miss && (strikes != STR_MAX) && (strikes_nx == STR_MAX);
  assign time_out   = tick && (seconds_left == SEC_W'(1));

  sec_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ARMED),
    .clr  (arm),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      explosion    <= 1'b0;
      disarm       <= 1'b0;
      seconds_left <= '0;
      strikes      <= '0;
      secret       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state        <= ARMED;
          armed        <= 1'b1;
          secret       <= code_sw;
          seconds_left <= SEC_INIT;
          strikes      <= '0;
        end
        ARMED: begin
          if (hit) begin
            // A correct guess wins even against a same-cycle final tick.
            state  <= DISARMED;
            armed  <= 1'b0;
            disarm <= 1'b1;
          end else begin
            if (miss && strikes != STR_MAX) strikes <= strikes_nx;
            if (tick && seconds_left != '0) seconds_left <= seconds_left - 1'b1;
            if (strike_out || time_out) begin
              state     <= EXPLODED;
              armed     <= 1'b0;
              explosion <= 1'b1;
            end
          end
        end
        DISARMED, EXPLODED: if (start) begin
          state     <= IDLE;
          armed     <= 1'b0;
          explosion <= 1'b0;
          disarm    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bomb_ctrl.sv
// Directed plus random stimulus against a game-rule reference model.
module tb_bomb_ctrl;
  localparam int TD = 4, CI = 3, MS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, enter = 1'b0;
  logic [3:0] code_sw = '0;
  logic       armed, explosion, disarm;
  logic [7:0] seconds_left;
  logic [1:0] strikes;

  int tests = 0, fails = 0;

  // reference model: game phase as flags, elapsed edges since arm
  bit m_armed, m_boom, m_safe;
  int m_secret, m_sec, m_strk, m_elapsed;

  bomb_ctrl #(.TICK_DIV(TD), .COUNT_INIT(CI), .MAX_STRIKES(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .enter(enter), .code_sw(code_sw),
    .armed(armed), .explosion(explosion), .disarm(disarm),
    .seconds_left(seconds_left), .strikes(strikes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit idle, tick;
    idle = !m_armed && !m_boom && !m_safe;
    if (rst) begin
      m_armed = 0; m_boom = 0; m_safe = 0;
      m_secret = 0; m_sec = 0; m_strk = 0; m_elapsed = 0;
    end else if (idle) begin
      if (start) begin
        m_armed = 1; m_secret = code_sw; m_sec = CI; m_strk = 0; m_elapsed = 0;
      end
    end else if (m_armed) begin
      m_elapsed++;
      tick = (m_elapsed % TD) == 0;
      if (enter && code_sw == m_secret) begin
        m_armed = 0; m_safe = 1;
      end else begin
        if (enter) begin
          m_strk++;
          if (m_strk >= MS) begin m_strk = MS; m_armed = 0; m_boom = 1; end
        end
        if (tick && m_sec > 0) begin
          m_sec--;
          if (m_sec == 0) begin m_armed = 0; m_boom = 1; end
        end
      end
    end else if (start) begin
      m_armed = 0; m_boom = 0; m_safe = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".armed"}, armed, m_armed);
    chk({tag, ".explosion"}, explosion, m_boom);
    chk({tag, ".disarm"}, disarm, m_safe);
    chk({tag, ".seconds"}, seconds_left, m_sec);
    chk({tag, ".strikes"}, strikes, m_strk);
    chk({tag, ".exclusive"}, explosion & disarm, 0);
  endtask

  task automatic step(input string tag, input bit r, input bit s, input bit e, input int c);
    rst = r; start = s; enter = e; code_sw = 4'(c);
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; start = 0; enter = 0;
    check_all(tag);
  endtask

  initial begin
    // reset and arm
    step("reset", 1, 1, 1, 4'hA);
    chk("reset.sec0", seconds_left, 0);
    step("arm", 0, 1, 0, 4'hA);
    chk("arm.armed", armed, 1);
    chk("arm.sec", seconds_left, 3);
    // timeout: decrements on edges 4, 8, 12 after arm
    for (int i = 1; i <= 12; i++) begin
      step("timeout", 0, 0, 0, 0);
      if (i == 4)  chk("timeout.sec2", seconds_left, 2);
      if (i == 8)  chk("timeout.sec1", seconds_left, 1);
    end
    chk("timeout.boom", explosion, 1);
    chk("timeout.sec0", seconds_left, 0);
    step("boom_hold", 0, 0, 0, 0);
    // terminal: enter ignored, start -> idle, start -> rearm
    step("term_enter", 0, 0, 1, 4'hA);
    chk("term_enter.boom", explosion, 1);
    step("to_idle", 0, 1, 0, 0);
    chk("to_idle.boom", explosion, 0);
    chk("to_idle.sec_hold", seconds_left, 0);
    step("rearm", 0, 1, 0, 4'hA);
    chk("rearm.sec", seconds_left, 3);
    // strikes
    step("strike1", 0, 0, 1, 4'h1);
    step("gap", 0, 0, 0, 0);
    step("strike2", 0, 0, 1, 4'h2);
    step("strike3", 0, 0, 1, 4'h3);
    chk("strike3.boom", explosion, 1);
    chk("strike3.cnt", strikes, 3);
    step("strike_freeze", 0, 0, 1, 4'h4);
    chk("strike_freeze.cnt", strikes, 3);
    // disarm race: correct enter on the final tick edge
    step("to_idle2", 0, 1, 0, 0);
    step("arm5", 0, 1, 0, 4'h5);
    for (int i = 1; i <= 11; i++) step("race_wait", 0, 0, 0, 0);
    step("race", 0, 0, 1, 4'h5);
    chk("race.disarm", disarm, 1);
    chk("race.boom", explosion, 0);
    chk("race.sec", seconds_left, 1);
    for (int i = 0; i < 6; i++) step("race_hold", 0, 0, 0, 0);
    // mid-game reset
    step("to_idle3", 0, 1, 0, 0);
    step("arm_mid", 0, 1, 0, 4'h7);
    for (int i = 1; i <= 5; i++) step("mid_wait", 0, 0, 0, 0);
    chk("mid.sec2", seconds_left, 2);
    step("mid_rst", 1, 0, 1, 4'h7);
    chk("mid_rst.armed", armed, 0);
    chk("mid_rst.boom", explosion, 0);
    chk("mid_rst.sec", seconds_left, 0);
    // random play
    for (int i = 0; i < 600; i++)
      step("rand", $urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bomb_ctrl.md
# bomb_ctrl

Game controller for the bomb-defusal board project. Latches a secret code from the switches at arm time, then runs a 1 Hz countdown, checks entered codes, and counts wrong attempts (strikes). Produces the `explosion` and `disarm` levels that drive the LED output stage, plus `seconds_left` and `strikes` for the 7-segment display path. All outputs are registered.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per countdown second; must be ≥ 2.
- `COUNT_INIT`, default 60: seconds loaded at arm; range 1..255.
- `MAX_STRIKES`, default 3: wrong entries that cause explosion; range 1..3.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  one-cycle pulse, debounced upstream; arms from IDLE; returns to IDLE from a terminal state
- `enter`  in  1  one-cycle pulse, debounced upstream; submits `code_sw` as a guess
- `code_sw`  in  4  switch code: sampled as the secret on arm, as the guess on `enter`
- `armed`  out  1  high in ARMED
- `explosion`  out  1  high in EXPLODED
- `disarm`  out  1  high in DISARMED
- `seconds_left`  out  8  remaining seconds
- `strikes`  out  2  wrong entries so far

## Operation
- States: IDLE, ARMED, DISARMED, EXPLODED.
- IDLE:
  - `start` → ARMED.
  - Arm action: secret ← `code_sw`; `seconds_left` ← COUNT_INIT; `strikes` ← 0; tick divider cleared.
  - `enter` is ignored.
- ARMED, with priority as follows within one cycle:
  - Step 1, `enter` with `code_sw` == secret → DISARMED. `seconds_left` freezes; a tick in the same cycle is discarded.
  - Step 2, `enter` with a wrong code → `strikes` +1. If the new value == MAX_STRIKES → EXPLODED. A same-cycle tick still decrements.
  - Step 3, tick:
    - if `seconds_left` == 1: `seconds_left` ← 0 and → EXPLODED.
    - otherwise `seconds_left` −1.
  - A correct `enter` therefore beats a final tick arriving in the same cycle.
  - `start` is ignored in ARMED.
- DISARMED / EXPLODED:
  - Terminal; all counters frozen.
  - `start` → IDLE. `seconds_left` and `strikes` hold their values until the next arm.
  - `enter` is ignored.
- Width rules:
  - `strikes` saturates at MAX_STRIKES and never wraps.
  - `seconds_left` never underflows below 0.

## Timing
- Reset values: state IDLE; `armed` = `explosion` = `disarm` = 0; `seconds_left` = 0; `strikes` = 0; secret = 0; tick divider = 0.
- `rst` has priority over every input in the same cycle. `rst` while ARMED aborts the game with no explosion.
- Outputs are registered from the state and counters. Latency is 1 cycle from the qualifying input edge:
  - `start` sampled at edge N → `armed` = 1 and `seconds_left` = COUNT_INIT after edge N.
  - a winning `enter` at edge N → `disarm` = 1 after edge N.
- Tick divider:
  - Counts 0..TICK_DIV−1 only while ARMED.
  - Tick is asserted in the cycle when the count equals TICK_DIV−1.
  - First decrement occurs exactly TICK_DIV cycles after the arm edge; later ones every TICK_DIV cycles.
  - Divider is cleared on arm and held at 0 outside ARMED.
- Explosion timing:
  - Timeout: `explosion` rises 1 cycle after the tick that takes `seconds_left` to 0, i.e. COUNT_INIT·TICK_DIV cycles after arm.
  - Strikes: `explosion` rises on the edge after the `enter` pulse that makes `strikes` reach MAX_STRIKES.
- `explosion` and `disarm` are mutually exclusive at all times.

## Structure
- Package `bomb_pkg`:
  - `state_t` enum {IDLE, ARMED, DISARMED, EXPLODED}.
  - Localparam widths: SEC_W = 8, STRIKE_W = 2, CODE_W = 4.
- Sub-module `sec_tick`:
  - Parameter TICK_DIV.
  - Ports `clk`, `rst`, `en`, `clr`, `tick`.
  - Driven with `en` = (state == ARMED) and `clr` = arm action.
- `bomb_ctrl` holds the FSM, the secret register, and both counters.

## Test plan
All scenarios use TICK_DIV=4, COUNT_INIT=3, MAX_STRIKES=3.
- Reset/arm: assert `rst`, then `start` with `code_sw`=4'hA → on the next cycle `armed`=1, `seconds_left`=3, `strikes`=0, `explosion`=`disarm`=0.
- Timeout: arm, no `enter` → `seconds_left` steps 3→2→1→0 at cycles 4, 8, 12 after the arm edge; `explosion`=1 from cycle 12 and held.
- Strikes: arm with 4'hA; `enter` with 4'h1, 4'h2, 4'h3 on separate cycles → `strikes` 1, 2, 3; `explosion`=1 the cycle after the third `enter`; `seconds_left` frozen.
- Disarm race: arm with 4'h5; pulse `enter` with 4'h5 in the same cycle as the final tick → `disarm`=1, `explosion` stays 0, `seconds_left`=1.
- Terminal/restart: in EXPLODED, pulse `enter` → no change. Pulse `start` → IDLE, all flags 0. Pulse `start` again → re-armed with `seconds_left`=3, `strikes`=0.
- Mid-game reset: `rst` while ARMED with `seconds_left`=2 → next cycle IDLE, `seconds_left`=0, `strikes`=0, no `explosion`.
